// File: rtl/mem_access_stage.sv
// Memory-access stage: data-memory req/ack handshake, upstream stall, store lane replication, load extraction.
// Define MEM_ACCESS_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without DM_ACK.
module mem_access_stage #(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EX_VALID,
  input  logic [DW-1:0] EX_ALU_RES,
  input  logic [DW-1:0] EX_STORE_DATA,
  input  logic          EX_MEM_RD,
  input  logic          EX_MEM_WR,
  input  logic [1:0]    EX_MEM_SIZE,
  input  logic          EX_MEM_UNSIGNED,
  input  logic          EX_RF_D_SEL,
  output logic          MEM_STALL,
  output logic          DM_REQ,
  output logic          DM_WE,
  output logic [DW-1:0] DM_ADDR,
  output logic [DW-1:0] DM_WDATA,
  output logic [3:0]    DM_BE,
  input  logic          DM_ACK,
  input  logic [DW-1:0] DM_RDATA,
  output logic          MEM_VALID,
  output logic [DW-1:0] MEM_ALU_RES,
  output logic [DW-1:0] MEM_DM_Q,
  output logic          MEM_RF_D_SEL,
  output logic          MEM_MISALIGN,
  output logic          MEM_TIMEOUT
);

  if (DW != 32) begin : g_dw_check
    $error("mem_access_stage supports only DW = 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_check
    $error("mem_access_stage TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {IDLE, ACCESS} state_e;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   byte_enables = 4'b0001 << a;
      2'b01:   byte_enables = 4'b0011 << {a[1], 1'b0};
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic [1:0] a,
                                               input logic uns, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract_load = {{24{b[7] & ~uns}}, b};
      2'b01:   extract_load = {{16{h[15] & ~uns}}, h};
      default: extract_load = rdata;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_alu_res_q, mem_alu_res_d;
  logic [31:0] mem_dm_q_q, mem_dm_q_d;
  logic        mem_rf_d_sel_q, mem_rf_d_sel_d;
  logic        mem_misalign_q, mem_misalign_d;
  logic        mem_timeout_q, mem_timeout_d;
  // Instruction context captured at acceptance, retired when the access ends.
  logic [31:0] pend_alu_res_q, pend_alu_res_d;
  logic        pend_rf_d_sel_q, pend_rf_d_sel_d;
  logic [1:0]  pend_size_q, pend_size_d;
  logic        pend_unsigned_q, pend_unsigned_d;
  logic        pend_load_q, pend_load_d;
  logic        stall;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic ex_mem_op, ex_misalign;
  assign ex_mem_op   = EX_MEM_RD | EX_MEM_WR;
  assign ex_misalign = ((EX_MEM_SIZE == 2'b01) && EX_ALU_RES[0]) ||
                       (EX_MEM_SIZE[1] && (EX_ALU_RES[1:0] != 2'b00));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    dm_req_d        = dm_req_q;
    dm_we_d         = dm_we_q;
    dm_addr_d       = dm_addr_q;
    dm_wdata_d      = dm_wdata_q;
    dm_be_d         = dm_be_q;
    mem_valid_d     = 1'b0;
    mem_alu_res_d   = mem_alu_res_q;
    mem_dm_q_d      = mem_dm_q_q;
    mem_rf_d_sel_d  = mem_rf_d_sel_q;
    mem_misalign_d  = 1'b0;
    mem_timeout_d   = 1'b0;
    pend_alu_res_d  = pend_alu_res_q;
    pend_rf_d_sel_d = pend_rf_d_sel_q;
    pend_size_d     = pend_size_q;
    pend_unsigned_d = pend_unsigned_q;
    pend_load_d     = pend_load_q;
    stall           = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (EX_VALID) begin
          if (!ex_mem_op || ex_misalign) begin
            mem_valid_d    = 1'b1;
            mem_alu_res_d  = EX_ALU_RES;
            mem_rf_d_sel_d = EX_RF_D_SEL;
            mem_dm_q_d     = '0;
            mem_misalign_d = ex_mem_op;
          end else begin
            stall           = 1'b1;
            state_d         = ACCESS;
            dm_req_d        = 1'b1;
            dm_we_d         = EX_MEM_WR;
            dm_addr_d       = {EX_ALU_RES[31:2], 2'b00};
            dm_be_d         = byte_enables(EX_MEM_SIZE, EX_ALU_RES[1:0]);
            dm_wdata_d      = lane_data(EX_MEM_SIZE, EX_STORE_DATA);
            pend_alu_res_d  = EX_ALU_RES;
            pend_rf_d_sel_d = EX_RF_D_SEL;
            pend_size_d     = EX_MEM_SIZE;
            pend_unsigned_d = EX_MEM_UNSIGNED;
            pend_load_d     = EX_MEM_RD & ~EX_MEM_WR;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d           = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (DM_ACK) begin
          state_d        = IDLE;
          dm_req_d       = 1'b0;
          dm_we_d        = 1'b0;
          mem_valid_d    = 1'b1;
          mem_alu_res_d  = pend_alu_res_q;
          mem_rf_d_sel_d = pend_rf_d_sel_q;
          mem_dm_q_d     = pend_load_q ? extract_load(pend_size_q, pend_alu_res_q[1:0],
                                                      pend_unsigned_q, DM_RDATA) : '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_VAL) begin
          state_d        = IDLE;
          dm_req_d       = 1'b0;
          dm_we_d        = 1'b0;
          mem_valid_d    = 1'b1;
          mem_timeout_d  = 1'b1;
          mem_alu_res_d  = pend_alu_res_q;
          mem_rf_d_sel_d = pend_rf_d_sel_q;
          mem_dm_q_d     = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
`else
        end else begin
          stall = 1'b1;
`endif
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dm_req_q        <= 1'b0;
      dm_we_q         <= 1'b0;
      dm_addr_q       <= '0;
      dm_wdata_q      <= '0;
      dm_be_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_alu_res_q   <= '0;
      mem_dm_q_q      <= '0;
      mem_rf_d_sel_q  <= 1'b0;
      mem_misalign_q  <= 1'b0;
      mem_timeout_q   <= 1'b0;
      pend_alu_res_q  <= '0;
      pend_rf_d_sel_q <= 1'b0;
      pend_size_q     <= '0;
      pend_unsigned_q <= 1'b0;
      pend_load_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      dm_req_q        <= dm_req_d;
      dm_we_q         <= dm_we_d;
      dm_addr_q       <= dm_addr_d;
      dm_wdata_q      <= dm_wdata_d;
      dm_be_q         <= dm_be_d;
      mem_valid_q     <= mem_valid_d;
      mem_alu_res_q   <= mem_alu_res_d;
      mem_dm_q_q      <= mem_dm_q_d;
      mem_rf_d_sel_q  <= mem_rf_d_sel_d;
      mem_misalign_q  <= mem_misalign_d;
      mem_timeout_q   <= mem_timeout_d;
      pend_alu_res_q  <= pend_alu_res_d;
      pend_rf_d_sel_q <= pend_rf_d_sel_d;
      pend_size_q     <= pend_size_d;
      pend_unsigned_q <= pend_unsigned_d;
      pend_load_q     <= pend_load_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  // Stall is combinational, so it is gated by reset to read 0 while rst_n is low.
  assign MEM_STALL    = stall & rst_n;
  assign DM_REQ       = dm_req_q;
  assign DM_WE        = dm_we_q;
  assign DM_ADDR      = dm_addr_q;
  assign DM_WDATA     = dm_wdata_q;
  assign DM_BE        = dm_be_q;
  assign MEM_VALID    = mem_valid_q;
  assign MEM_ALU_RES  = mem_alu_res_q;
  assign MEM_DM_Q     = mem_dm_q_q;
  assign MEM_RF_D_SEL = mem_rf_d_sel_q;
  assign MEM_MISALIGN = mem_misalign_q;
  assign MEM_TIMEOUT  = mem_timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push expected retirements, a monitor compares them.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EX_VALID = 1'b0;
  logic [31:0] EX_ALU_RES = '0;
  logic [31:0] EX_STORE_DATA = '0;
  logic        EX_MEM_RD = 1'b0;
  logic        EX_MEM_WR = 1'b0;
  logic [1:0]  EX_MEM_SIZE = '0;
  logic        EX_MEM_UNSIGNED = 1'b0;
  logic        EX_RF_D_SEL = 1'b0;
  logic        MEM_STALL;
  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic [3:0]  DM_BE;
  logic        DM_ACK = 1'b0;
  logic [31:0] DM_RDATA = '0;
  logic        MEM_VALID;
  logic [31:0] MEM_ALU_RES;
  logic [31:0] MEM_DM_Q;
  logic        MEM_RF_D_SEL;
  logic        MEM_MISALIGN;
  logic        MEM_TIMEOUT;

  mem_access_stage #(.DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_VALID(EX_VALID), .EX_ALU_RES(EX_ALU_RES), .EX_STORE_DATA(EX_STORE_DATA),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_WR(EX_MEM_WR), .EX_MEM_SIZE(EX_MEM_SIZE),
    .EX_MEM_UNSIGNED(EX_MEM_UNSIGNED), .EX_RF_D_SEL(EX_RF_D_SEL),
    .MEM_STALL(MEM_STALL), .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR),
    .DM_WDATA(DM_WDATA), .DM_BE(DM_BE), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
    .MEM_VALID(MEM_VALID), .MEM_ALU_RES(MEM_ALU_RES), .MEM_DM_Q(MEM_DM_Q),
    .MEM_RF_D_SEL(MEM_RF_D_SEL), .MEM_MISALIGN(MEM_MISALIGN), .MEM_TIMEOUT(MEM_TIMEOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] dmq;
    logic        rf;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] dmq,
                          input logic rf, input logic mis, input logic to);
    exp_t e;
    e.alu = alu; e.dmq = dmq; e.rf = rf; e.mis = mis; e.to = to;
    sb_q.push_back(e);
  endtask

  // Monitor: every retirement pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && MEM_VALID) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_mem_valid: got MEM_VALID=1 alu=0x%08h, expected no retirement", MEM_ALU_RES);
      end else begin
        mon_e = sb_q.pop_front();
        check("mem_alu_res",  MEM_ALU_RES,  mon_e.alu);
        check("mem_dm_q",     MEM_DM_Q,     mon_e.dmq);
        check("mem_rf_d_sel", 32'(MEM_RF_D_SEL), 32'(mon_e.rf));
        check("mem_misalign", 32'(MEM_MISALIGN), 32'(mon_e.mis));
        check("mem_timeout",  32'(MEM_TIMEOUT),  32'(mon_e.to));
      end
    end
  end

  task automatic drive_ex(input logic [31:0] addr, input logic [1:0] size, input logic rd,
                          input logic wr, input logic uns, input logic rf, input logic [31:0] sdata);
    EX_VALID = 1'b1; EX_ALU_RES = addr; EX_MEM_SIZE = size; EX_MEM_RD = rd; EX_MEM_WR = wr;
    EX_MEM_UNSIGNED = uns; EX_RF_D_SEL = rf; EX_STORE_DATA = sdata;
  endtask

  // Instructions that retire in one cycle: non-memory ops and misaligned accesses.
  task automatic issue_single(input logic [31:0] addr, input logic [1:0] size, input logic rd,
                              input logic wr, input logic rf, input logic mis, input string tag);
    drive_ex(addr, size, rd, wr, 1'b0, rf, 32'h5555_AAAA);
    push_exp(addr, 32'h0, rf, mis, 1'b0);
    @(negedge clk);
    check({tag, "_stall"}, 32'(MEM_STALL), 32'h0);
    @(posedge clk); #1;
    EX_VALID = 1'b0;
    check({tag, "_no_req"}, 32'(DM_REQ), 32'h0);
  endtask

  // Aligned memory op with `waits` ACCESS cycles before DM_ACK.
  task automatic do_mem(input logic [31:0] addr, input logic [1:0] size, input logic rd,
                        input logic wr, input logic uns, input logic rf, input logic [31:0] sdata,
                        input int waits, input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_dmq, input string tag);
    int stalls = 0;
    drive_ex(addr, size, rd, wr, uns, rf, sdata);
    push_exp(addr, exp_dmq, rf, 1'b0, 1'b0);
    @(negedge clk);
    if (MEM_STALL) stalls++;
    @(posedge clk); #1;
    check({tag, "_req"},   32'(DM_REQ), 32'h1);
    check({tag, "_we"},    32'(DM_WE),  32'(wr));
    check({tag, "_addr"},  DM_ADDR,     {addr[31:2], 2'b00});
    check({tag, "_be"},    32'(DM_BE),  32'(exp_be));
    check({tag, "_wdata"}, DM_WDATA,    exp_wdata);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (MEM_STALL) stalls++;
      @(posedge clk); #1;
    end
    if (waits > 0) check({tag, "_addr_held"}, DM_ADDR, {addr[31:2], 2'b00});
    DM_ACK = 1'b1; DM_RDATA = rdata;
    @(negedge clk);
    check({tag, "_ack_stall"}, 32'(MEM_STALL), 32'h0);
    @(posedge clk); #1;
    DM_ACK = 1'b0; DM_RDATA = 32'hDEAD_0000; EX_VALID = 1'b0;
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 1));
    check({tag, "_req_drop"}, 32'(DM_REQ), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_stall",     32'(MEM_STALL), 32'h0);
    check("rst_req",       32'(DM_REQ),    32'h0);
    check("rst_valid",     32'(MEM_VALID), 32'h0);
    check("rst_alu_res",   MEM_ALU_RES,    32'h0);
    check("rst_dm_q",      MEM_DM_Q,       32'h0);
    check("rst_be",        32'(DM_BE),     32'h0);
    check("rst_timeout",   32'(MEM_TIMEOUT), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while an access is outstanding.
    drive_ex(32'h0000_0100, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("pre_rst_req", 32'(DM_REQ), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",   32'(DM_REQ),    32'h0);
    check("async_rst_stall", 32'(MEM_STALL), 32'h0);
    check("async_rst_valid", 32'(MEM_VALID), 32'h0);
    EX_VALID = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    DM_ACK = 1'b1; DM_RDATA = 32'h1234_5678;
    @(posedge clk); #1;
    DM_ACK = 1'b0;
    @(negedge clk);
    check("late_ack_valid", 32'(MEM_VALID), 32'h0);
    check("late_ack_req",   32'(DM_REQ),    32'h0);
    @(posedge clk); #1;

    issue_single(32'h0000_1234, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "nonmem");
    issue_single(32'h0000_0042, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, "mis_word");
    issue_single(32'h0000_0005, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, "mis_half_st");

    do_mem(32'h0000_0103, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 3, 32'h80FF_7F01,
           4'b1000, 32'h0000_0000, 32'hFFFF_FF80, "lb_signed");
    // Back-to-back: each op below starts in the IDLE cycle after the previous retirement.
    do_mem(32'h0000_0202, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 0, 32'h9ABC_5678,
           4'b1100, 32'h0000_0000, 32'h0000_9ABC, "lhu");
    do_mem(32'h0000_0041, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 1, 32'hFFFF_FFFF,
           4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, "sb");
    do_mem(32'h0000_0010, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2, 32'h1234_8001,
           4'b0011, 32'h0000_0000, 32'hFFFF_8001, "lh_signed");
    do_mem(32'h0000_0001, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 0, 32'h0000_F000,
           4'b0010, 32'h0000_0000, 32'h0000_00F0, "lbu");
    do_mem(32'h0000_0300, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1, 32'hDEAD_BEEF,
           4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, "lw");
    do_mem(32'h0000_0008, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1122_3344, 0, 32'hFFFF_FFFF,
           4'b1111, 32'h1122_3344, 32'h0000_0000, "rd_wr_store");
    do_mem(32'h0000_0006, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBEEF_CAFE, 0, 32'h0,
           4'b1100, 32'hCAFE_CAFE, 32'h0000_0000, "sh");

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int  stalled = 0;
      bit  ended = 0;
      drive_ex(32'h0000_0500, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      push_exp(32'h0000_0500, 32'h0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("to_entry_stall", 32'(MEM_STALL), 32'h1);
      @(posedge clk); #1;
      for (int i = 0; i < 20 && !ended; i++) begin
        @(negedge clk);
        if (MEM_STALL) stalled++;
        else ended = 1;
        @(posedge clk); #1;
      end
      EX_VALID = 1'b0;
      check("to_terminal_seen", 32'(ended),   32'h1);
      check("to_stalled_access", 32'(stalled), 32'h4);
      check("to_req_drop",       32'(DM_REQ),  32'h0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register.
- Takes the EX result and control, runs a req/ack handshake with data memory, and stalls upstream while an access is outstanding.
- Aligns, sign-extends and zero-extends load data.
- Presents registered MEM_ALU_RES, MEM_DM_Q and MEM_RF_D_SEL to the MEM/WB register.

Parameters:
- DW, 32, data and address width; the design supports only 32.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; used only when the optional feature is compiled in; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EX_VALID  in  1  instruction present in EX/MEM.
- EX_ALU_RES  in  32  ALU result; also the memory byte address.
- EX_STORE_DATA  in  32  store data, right-justified.
- EX_MEM_RD  in  1  load.
- EX_MEM_WR  in  1  store.
- EX_MEM_SIZE  in  2  00 byte, 01 half, 10/11 word.
- EX_MEM_UNSIGNED  in  1  zero-extend loads when 1.
- EX_RF_D_SEL  in  1  writeback mux select, passed through.
- MEM_STALL  out  1  hold EX/MEM and everything upstream.
- DM_REQ  out  1  memory request, registered.
- DM_WE  out  1  write enable, registered.
- DM_ADDR  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- DM_WDATA  out  32  lane-replicated store data, registered.
- DM_BE  out  4  byte enables, registered.
- DM_ACK  in  1  memory done; read data valid the same cycle.
- DM_RDATA  in  32  read word.
- MEM_VALID  out  1  one-cycle pulse per retired instruction.
- MEM_ALU_RES  out  32  registered EX_ALU_RES.
- MEM_DM_Q  out  32  extended load data; 0 for non-loads.
- MEM_RF_D_SEL  out  1  registered EX_RF_D_SEL.
- MEM_MISALIGN  out  1  pulse alongside MEM_VALID for a misaligned access.
- MEM_TIMEOUT  out  1  pulse alongside MEM_VALID on abort; tied 0 without the feature.

Behaviour:
- Reset (async assert): state IDLE, and every output above, including MEM_STALL, is 0. Reset mid-ACCESS drops DM_REQ immediately. A late DM_ACK after release is ignored because IDLE ignores DM_ACK.
- FSM states: IDLE and ACCESS.
- Misaligned definition: half access with addr[0]=1; word access with addr[1:0]!=0.
- IDLE, EX_VALID=0: MEM_VALID=0 next edge; MEM_* data outputs hold their values.
- IDLE, EX_VALID=1, no memory op: next edge MEM_VALID=1, MEM_ALU_RES/MEM_RF_D_SEL captured, MEM_DM_Q=0. Latency 1, no stall.
- IDLE, memory op misaligned: same as the non-memory case, plus MEM_MISALIGN=1. No DM_REQ is issued.
- IDLE, memory op aligned: MEM_STALL=1 combinationally in that cycle. Next edge: DM_REQ=1, DM_WE=EX_MEM_WR, address/BE/WDATA latched, and the FSM enters ACCESS.
- RD and WR both set: handled as a store; MEM_DM_Q=0.
- ACCESS: MEM_STALL=1 unless DM_ACK=1. DM_REQ, DM_WE, DM_ADDR, DM_WDATA and DM_BE stay stable until DM_ACK is sampled.
- ACCESS with DM_ACK=1: MEM_STALL=0 that cycle. Next edge: DM_REQ=0, MEM_VALID=1, extended data captured (loads), state IDLE.
- A back-to-back memory op is accepted in the IDLE cycle that follows. Minimum memory-op latency is 2 cycles from acceptance to MEM_VALID (ACK in the first ACCESS cycle).
- DM_BE encoding:
  - byte: 4'b0001<<a[1:0].
  - half: 4'b0011<<{a[1],1'b0}.
  - word: 4'b1111.
- DM_WDATA encoding:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Load extraction:
  - byte lane = DM_RDATA[8*a[1:0] +: 8].
  - half = DM_RDATA[16*a[1] +: 16].
  - Sign-extend unless EX_MEM_UNSIGNED=1; the unsigned bit is latched at acceptance.
- Stores: MEM_VALID still pulses; MEM_DM_Q=0; MEM_RF_D_SEL passes through.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- With the macro: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without DM_ACK.
  - When the count equals TIMEOUT_CYCLES, the next edge drops DM_REQ, pulses MEM_VALID and MEM_TIMEOUT, sets MEM_DM_Q=0 and returns to IDLE.
  - MEM_STALL is 0 in that terminal cycle.
  - DM_ACK arriving in the terminal cycle wins: the access completes normally with no timeout.
- Without the macro: ACCESS waits indefinitely, no counter exists, and MEM_TIMEOUT is constant 0.

Test Plan:
- Reset sequence:
  - Drive rst_n=0 mid-ACCESS (DM_REQ=1) -> DM_REQ, MEM_STALL and MEM_VALID go 0 asynchronously.
  - After release, DM_ACK=1 for one cycle -> no MEM_VALID.
- Non-memory pass-through: EX_VALID=1, EX_ALU_RES=0x0000_1234, EX_RF_D_SEL=0 -> one edge later MEM_VALID=1, MEM_ALU_RES=0x1234, MEM_DM_Q=0, MEM_STALL never 1.
- Signed byte load:
  - Stimulus: addr 0x103, size 00, unsigned 0, DM_ACK after 3 wait cycles, DM_RDATA=0x80FF_7F01.
  - Response: DM_ADDR=0x100, DM_BE=4'b1000, MEM_STALL high 4 cycles, MEM_DM_Q=0xFFFF_FF80.
- Unsigned half load: addr 0x202, DM_RDATA=0x9ABC_5678 -> MEM_DM_Q=0x0000_9ABC.
- Byte store and misaligned access:
  - Byte store: addr 0x41, data 0x0000_00A5 -> DM_WE=1, DM_BE=4'b0010, DM_WDATA=0xA5A5_A5A5.
  - Misaligned word load: addr 0x42 -> no DM_REQ, MEM_MISALIGN=1 with MEM_VALID.
- Timeout (MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4): DM_ACK held 0 -> MEM_TIMEOUT=1 with MEM_VALID after 4 ACCESS cycles, DM_REQ=0, MEM_DM_Q=0.
